// File: rtl/half_adder.sv
// 1-bit half adder with a registered copy of its results and a saturating
// counter of clock edges that see a carry.
module half_adder #(
    parameter int CNT_W = 8
) (
    input  logic             A,
    input  logic             B,
    output logic             sum,
    output logic             carry,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    output logic             sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sum_d;
    logic             carry_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Pure half-adder path: depends only on A and B, so 4-port users never see clk/reset effects.
    always_comb begin
        sum   = A ^ B;
        carry = A & B;
    end

    always_comb begin
        sum_d   = sum;
        carry_d = carry;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (carry && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: directed steps plus random cycles,
// compared against an arithmetic reference model (8-bit and 2-bit counters).
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cnt_clr;

    logic       sum8, carry8, sq8, cq8;
    logic [7:0] cnt8;
    logic       sum2, carry2, sq2, cq2;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_sq   = 0;
    int m_cq   = 0;
    int m_cnt8 = 0;
    int m_cnt2 = 0;

    always #5 clk = ~clk;

    half_adder #(.CNT_W(8)) dut8 (
        .A(a), .B(b), .sum(sum8), .carry(carry8),
        .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .sum_q(sq8), .carry_q(cq8), .carry_cnt(cnt8)
    );

    half_adder #(.CNT_W(2)) dut2 (
        .A(a), .B(b), .sum(sum2), .carry(carry2),
        .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .sum_q(sq2), .carry_q(cq2), .carry_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        int s;
        s = int'(a) + int'(b);
        check("sum8",      32'(sum8),           32'(s % 2));
        check("carry8",    32'(carry8),         32'(s / 2));
        check("add8",      32'({carry8, sum8}), 32'(s));
        check("add2",      32'({carry2, sum2}), 32'(s));
    endtask

    task automatic check_regs();
        check("sum_q8",   32'(sq8),  32'(m_sq));
        check("carry_q8", 32'(cq8),  32'(m_cq));
        check("sum_q2",   32'(sq2),  32'(m_sq));
        check("carry_q2", 32'(cq2),  32'(m_cq));
        check("cnt8",     32'(cnt8), 32'(m_cnt8));
        check("cnt2",     32'(cnt2), 32'(m_cnt2));
    endtask

    task automatic set_in(input logic ia, input logic ib, input logic iclr);
        a       = ia;
        b       = ib;
        cnt_clr = iclr;
        #1;
        check_comb();
    endtask

    task automatic model_reset();
        m_sq   = 0;
        m_cq   = 0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    // One rising edge: advance the model from the inputs seen at the edge, then check.
    task automatic tick();
        int s;
        @(posedge clk);
        if (rst_n) begin
            s    = int'(a) + int'(b);
            m_sq = s % 2;
            m_cq = s / 2;
            if (cnt_clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (s == 2) begin
                m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
            end
        end
        #1;
        check_regs();
    endtask

    initial begin
        int sat_exp [6] = '{1, 2, 3, 3, 3, 3};
        logic ra, rb, rc;

        rst_n   = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        cnt_clr = 1'b0;

        // Combinational sweep while held in reset; registered outputs stay zero
        set_in(1'b0, 1'b0, 1'b0); check_regs(); #9;
        set_in(1'b1, 1'b0, 1'b0); check_regs(); #9;
        set_in(1'b0, 1'b1, 1'b0); check_regs(); #9;
        set_in(1'b1, 1'b1, 1'b0); check_regs(); #9;
        set_in(1'b0, 1'b0, 1'b0); check_regs(); #9;

        @(negedge clk);
        rst_n = 1'b1;

        // Registered latency
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        check("lat_carry_q", 32'(cq8), 32'd1);
        check("lat_sum_q",   32'(sq8), 32'd0);
        set_in(1'b1, 1'b0, 1'b0);
        tick();
        check("lat2_sum_q",   32'(sq8), 32'd1);
        check("lat2_carry_q", 32'(cq8), 32'd0);

        // Clear, then saturation of the 2-bit counter
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat_cnt2", 32'(cnt2), 32'(sat_exp[i]));
        end

        // Clear wins over increment on the same edge
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        check("clr_pri_cnt2", 32'(cnt2), 32'd0);
        check("clr_pri_cnt8", 32'(cnt8), 32'd0);
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        check("post_clr_cnt2", 32'(cnt2), 32'd1);

        // Bring the wide counter to 5 with carry_q high, then reset between edges
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_cnt8",    32'(cnt8), 32'd5);
        check("pre_rst_carry_q", 32'(cq8),  32'd1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_carry_q", 32'(cq8),  32'd0);
        check("rst_cnt8",    32'(cnt8), 32'd0);
        check_regs();
        set_in(1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Random cycles against the model
        for (int i = 0; i < 60; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 9) == 0);
            set_in(ra, rb, rc);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- 1-bit half adder: combinational sum and carry of two single-bit operands.
- Adds a registered copy of both results and a saturating carry-event counter for pipelined and monitoring use.
- Leaf arithmetic cell; instantiated positionally by existing datapath and bench code as (A, B, sum, carry).

Parameters:
- CNT_W, 8, width of the carry-event counter carry_cnt; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; drives the registered outputs and counter only.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  operand A.
- B  input  1  operand B.
- sum  output  1  combinational A XOR B.
- carry  output  1  combinational A AND B.
- sum_q  output  1  sum registered on the clk rising edge.
- carry_q  output  1  carry registered on the clk rising edge.
- carry_cnt  output  CNT_W  saturating count of clock edges sampled with carry=1.
- cnt_clr  input  1  synchronous clear of carry_cnt; active-high.

Behaviour:
- Declaration order is A, B, sum, carry, clk, rst_n, cnt_clr, sum_q, carry_q, carry_cnt.
- This order keeps existing 4-port positional instantiations valid. Unconnected trailing inputs must not affect sum or carry.
- Combinational path:
  - sum = A ^ B; carry = A & B.
  - Zero latency, no dependence on clk, rst_n or cnt_clr.
  - Truth table (A B -> sum carry): 00->0 0, 10->1 0, 01->1 0, 11->0 1.
  - {carry,sum} always equals A+B as a 2-bit unsigned value.
- Reset:
  - rst_n low asynchronously forces sum_q=0, carry_q=0, carry_cnt=0, independent of clk.
  - This holds immediately, including mid-operation.
  - Release is sampled on the next rising clk edge.
  - sum and carry remain live during reset.
- Registered path, on each clk rising edge with rst_n high: sum_q <= A^B and carry_q <= A&B. Latency is 1 cycle.
- Counter, on each clk rising edge with rst_n high:
  - If cnt_clr=1: carry_cnt <= 0. Clear has priority over increment on the same edge.
  - Else if carry=1 and carry_cnt < 2^CNT_W-1: carry_cnt <= carry_cnt+1.
  - Else: hold.
  - At all-ones the counter saturates and never wraps.
- No X propagation from the unused clk or cnt_clr when they are tied off. The combinational outputs alone define pure half-adder use.

Test Plan:
- Combinational sweep, no clock: A,B = 00, 10, 01, 11, 00 at 10 ns steps -> sum,carry = 0/0, 1/0, 1/0, 0/1, 0/0, each valid within the step.
- Registered latency: rst_n released, A=1 B=1 before edge N -> carry_q=1 and sum_q=0 after edge N. Then A=1 B=0 -> sum_q=1 and carry_q=0 after edge N+1.
- Async reset mid-run: carry_q=1 and carry_cnt=5, drop rst_n between edges -> carry_q=0 and carry_cnt=0 immediately. Meanwhile sum and carry still follow A,B.
- Counter saturation with CNT_W=2: A=B=1 held for 6 edges -> carry_cnt = 1, 2, 3, 3, 3, 3.
- Clear priority: carry_cnt=3, A=B=1 and cnt_clr=1 on one edge -> carry_cnt=0. Next edge with cnt_clr=0 -> carry_cnt=1.
- Exhaustive check: all 4 input combinations over random cycles -> {carry,sum} == A+B every time, and registered outputs match the combinational values of the previous edge.
